// File: rtl/uart_apb_pkg.sv
// Shared types and constants for the UART APB requester and its command sources.
package uart_apb_pkg;

  // APB bus geometry
  localparam int APB_AW = 32;
  localparam int APB_DW = 32;
  localparam int APB_SW = 4;

  // uart_top register map (byte offsets)
  localparam logic [APB_AW-1:0] UART_REG_DATA   = 32'h0000_0000;
  localparam logic [APB_AW-1:0] UART_REG_CTRL   = 32'h0000_0004;
  localparam logic [APB_AW-1:0] UART_REG_STATUS = 32'h0000_0008;
  localparam logic [APB_AW-1:0] UART_REG_BAUD   = 32'h0000_000C;

  // Requester FSM states
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/uart_apb_wait_cnt.sv
// Saturating ACCESS-phase wait counter; o_hit flags that the timeout limit is reached.
module uart_apb_wait_cnt #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);

  localparam logic [CNT_W-1:0] LP_LIMIT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LP_MAX    = '1;
  localparam bit               LP_ENABLE = (TIMEOUT_CYCLES != 0);

  logic [CNT_W-1:0] r_cnt;

  // Count enabled cycles, clear on request, hold at all-ones instead of wrapping
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LP_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A zero limit means the timeout is disabled
  assign o_hit = LP_ENABLE && (r_cnt == LP_LIMIT);

endmodule

// File: rtl/uart_apb_master.sv
// APB4 requester: one register transfer per command, response with read data,
// slave error and timeout status. All outputs come straight from registers.
module uart_apb_master
  import uart_apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic              pclk,
  input  logic              preset,
  // command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [APB_AW-1:0] cmd_addr,
  input  logic [APB_DW-1:0] cmd_wdata,
  input  logic [APB_SW-1:0] cmd_strb,
  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [APB_DW-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  // APB requester port
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [APB_AW-1:0] paddr,
  output logic [APB_DW-1:0] pwdata,
  output logic [APB_SW-1:0] pstrb,
  input  logic [APB_DW-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_e        r_state;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [APB_DW-1:0] r_rsp_rdata;
  logic              r_rsp_slverr;
  logic              r_rsp_timeout;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [APB_AW-1:0] r_paddr;
  logic [APB_DW-1:0] r_pwdata;
  logic [APB_SW-1:0] r_pstrb;

  logic w_accept;
  logic w_in_access;
  logic w_timeout_hit;

  assign w_accept    = (r_state == S_IDLE) && r_cmd_ready && cmd_valid;
  assign w_in_access = (r_state == S_ACCESS);

  uart_apb_wait_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_wait_cnt (
    .i_clk (pclk),
    .i_rst (preset),
    .i_clr (w_accept),
    .i_en  (w_in_access),
    .o_hit (w_timeout_hit)
  );

  // Transfer FSM with all outputs registered; reset drops any in-flight transfer
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_slverr  <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // Reads never carry data or strobes onto the bus
            r_cmd_ready <= 1'b0;
            r_psel      <= 1'b1;
            r_penable   <= 1'b0;
            r_pwrite    <= cmd_write;
            r_paddr     <= cmd_addr;
            r_pwdata    <= cmd_write ? cmd_wdata : '0;
            r_pstrb     <= cmd_write ? cmd_strb : '0;
            r_state     <= S_SETUP;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          // pready wins over a timeout landing in the same cycle
          if (pready || w_timeout_hit) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= (pready && !r_pwrite) ? prdata : '0;
            r_rsp_slverr  <= pready ? pslverr : 1'b0;
            r_rsp_timeout <= !pready;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_slverr  <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_slverr  = r_rsp_slverr;
  assign rsp_timeout = r_rsp_timeout;
  assign psel        = r_psel;
  assign penable     = r_penable;
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign pstrb       = r_pstrb;

endmodule

// File: tb/tb_uart_apb_master.sv
// Bench for uart_apb_master: behavioural APB completer, vector table and
// response scoreboard, plus reset-abort and response-stall sequences.
module tb_uart_apb_master;
  import uart_apb_pkg::*;

  localparam int TO    = 4;
  localparam int NEVER = 255;
  localparam int NV    = 7;

  logic        pclk;
  logic        preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;

  uart_apb_master #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          wait_n;
    logic [31:0] prd;
    logic        err;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_lat;
    int          exp_acc;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          lat;
    int          acc;
    int          acc_cyc;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pwrite;
  } sb_t;

  vec_t vecs [NV];
  sb_t  sbq [$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // completer configuration and bus monitor state
  int          cfg_wait = 0;
  logic [31:0] cfg_rdata = '0;
  logic        cfg_err = 1'b0;
  int          acc_idx = 0;
  int          mon_acc = 0;
  logic        mon_stable = 1'b1;
  logic [31:0] mon_addr = '0, mon_wdata = '0;
  logic [3:0]  mon_strb = '0;
  logic        mon_write = 1'b0;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  // Completer: ready after cfg_wait wait states; pslverr/prdata are junk while not ready
  always @(negedge pclk) begin
    if (psel && penable) begin
      if (acc_idx == cfg_wait) begin
        pready = 1'b1; prdata = cfg_rdata; pslverr = cfg_err;
      end else begin
        pready = 1'b0; prdata = 32'hDEAD_BEEF; pslverr = 1'b1;
      end
      acc_idx = acc_idx + 1;
      mon_acc = mon_acc + 1;
      if (paddr !== mon_addr || pwdata !== mon_wdata || pstrb !== mon_strb || pwrite !== mon_write)
        mon_stable = 1'b0;
    end else begin
      pready = 1'b0; prdata = 32'hDEAD_BEEF; pslverr = 1'b0; acc_idx = 0;
      if (psel) begin
        mon_addr = paddr; mon_wdata = pwdata; mon_strb = pstrb; mon_write = pwrite;
        mon_acc = 0; mon_stable = 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic push, input sb_t e_in);
    sb_t e;
    bit  ok;
    e  = e_in;
    ok = 0;
    @(posedge pclk); #1;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb; cmd_valid = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge pclk);
      if (cmd_ready) ok = 1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL cmd_accept: cmd_ready=%0b want 1 within 40 cycles", cmd_ready);
    end
    e.acc_cyc = cyc;
    if (push && ok) sbq.push_back(e);
    @(posedge pclk); #1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
  endtask

  task automatic wait_rsp(output sb_t got);
    bit  seen;
    sb_t e;
    seen = 0;
    got  = '{default: 0};
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge pclk);
      if (rsp_valid) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL rsp_wait: rsp_valid=%0b want 1 within 60 cycles", rsp_valid);
      return;
    end
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL sb_pop: queue size 0 want >0");
      return;
    end
    e   = sbq.pop_front();
    got = e;
    chk("rsp_rdata",   rsp_rdata,   e.rdata);
    chk("rsp_slverr",  {31'd0, rsp_slverr},  {31'd0, e.err});
    chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.to});
    chk("latency",     32'(cyc - e.acc_cyc), 32'(e.lat));
    chk("access_cycles", 32'(mon_acc), 32'(e.acc));
    chk("setup_paddr",  mon_addr,  e.paddr);
    chk("setup_pwdata", mon_wdata, e.pwdata);
    chk("setup_pstrb",  {28'd0, mon_strb},  {28'd0, e.pstrb});
    chk("setup_pwrite", {31'd0, mon_write}, {31'd0, e.pwrite});
    chk("apb_stable",   {31'd0, mon_stable}, 32'd1);
    chk("resp_psel",    {31'd0, psel}, 32'd0);
    chk("resp_apb_zero", paddr | pwdata | {28'd0, pstrb}, 32'd0);
    chk("resp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    if (rsp_ready) begin
      @(negedge pclk);
      chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("post_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sb_t e;
    sb_t g;
    bit  seen_rsp;

    //        wr    addr             wdata          strb  wait   prdata         err   exp_rdata      e_err e_to lat acc
    vecs[0] = '{1'b1, UART_REG_CTRL,   32'h0000_00A5, 4'h1, 0,     32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 3, 1};
    vecs[1] = '{1'b0, UART_REG_STATUS, 32'hCAFE_F00D, 4'hF, 3,     32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 6, 4};
    vecs[2] = '{1'b0, 32'h0000_0FFC,   32'h0000_0000, 4'h0, 0,     32'hBAD0_0001, 1'b1, 32'hBAD0_0001, 1'b1, 1'b0, 3, 1};
    vecs[3] = '{1'b0, UART_REG_BAUD,   32'h0000_0000, 4'h0, NEVER, 32'h7777_7777, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 7, 5};
    vecs[4] = '{1'b1, UART_REG_DATA,   32'h0000_005A, 4'h0, 2,     32'h5555_AAAA, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 5, 3};
    vecs[5] = '{1'b0, UART_REG_DATA,   32'h0000_0000, 4'h0, TO,    32'h0F0F_F0F0, 1'b0, 32'h0F0F_F0F0, 1'b0, 1'b0, 7, 5};
    vecs[6] = '{1'b1, UART_REG_CTRL,   32'h8000_0001, 4'hC, NEVER, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 7, 5};

    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; rsp_ready = 1'b1;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;

    // reset values
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_psel_pen",  {30'd0, psel, penable}, 32'd0);
    chk("rst_rsp_fields", rsp_rdata | {30'd0, rsp_slverr, rsp_timeout}, 32'd0);
    chk("rst_apb_fields", paddr | pwdata | {27'd0, pwrite, pstrb}, 32'd0);
    @(posedge pclk); #1;
    preset = 1'b0;
    repeat (2) @(negedge pclk);
    chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // table-driven transfers
    for (int i = 0; i < NV; i++) begin
      cfg_wait = vecs[i].wait_n; cfg_rdata = vecs[i].prd; cfg_err = vecs[i].err;
      e.rdata  = vecs[i].exp_rdata;
      e.err    = vecs[i].exp_err;
      e.to     = vecs[i].exp_to;
      e.lat    = vecs[i].exp_lat;
      e.acc    = vecs[i].exp_acc;
      e.acc_cyc = 0;
      e.paddr  = vecs[i].addr;
      e.pwrite = vecs[i].wr;
      e.pwdata = vecs[i].wr ? vecs[i].wdata : 32'h0;
      e.pstrb  = vecs[i].wr ? vecs[i].strb : 4'h0;
      issue_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, 1'b1, e);
      wait_rsp(g);
    end

    // reset in the second ACCESS cycle aborts the transfer without a response
    cfg_wait = NEVER; cfg_rdata = 32'h1111_2222; cfg_err = 1'b0;
    e = '{default: 0};
    issue_cmd(1'b0, UART_REG_STATUS, 32'h0, 4'h0, 1'b0, e);
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    preset = 1'b1;
    @(negedge pclk);
    chk("abort_in_access", {30'd0, psel, penable}, 32'd3);
    @(posedge pclk); #1;
    preset = 1'b0;
    @(negedge pclk);
    chk("abort_psel_pen", {30'd0, psel, penable}, 32'd0);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
    seen_rsp = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge pclk);
      if (rsp_valid) seen_rsp = 1;
    end
    chk("abort_no_rsp", {31'd0, seen_rsp}, 32'd0);
    chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // response stall: second command waits for the first response handshake
    rsp_ready = 1'b0;
    cfg_wait = 1; cfg_rdata = 32'hFFFF_0000; cfg_err = 1'b1;
    e.rdata = 32'h0; e.err = 1'b1; e.to = 1'b0; e.lat = 4; e.acc = 2; e.acc_cyc = 0;
    e.paddr = UART_REG_BAUD; e.pwrite = 1'b1; e.pwdata = 32'h0000_0364; e.pstrb = 4'h3;
    issue_cmd(1'b1, UART_REG_BAUD, 32'h0000_0364, 4'h3, 1'b1, e);
    cmd_write = 1'b0; cmd_addr = UART_REG_STATUS; cmd_wdata = 32'h0; cmd_strb = 4'h0;
    cmd_valid = 1'b1;
    wait_rsp(g);
    cfg_wait = 0; cfg_rdata = 32'h0000_0060; cfg_err = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge pclk);
      chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_rsp_rdata", rsp_rdata, g.rdata);
      chk("stall_rsp_flags", {30'd0, rsp_slverr, rsp_timeout}, {30'd0, g.err, g.to});
      chk("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("stall_psel", {31'd0, psel}, 32'd0);
    end
    @(posedge pclk); #1;
    rsp_ready = 1'b1;
    @(negedge pclk);
    chk("hs_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("hs_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge pclk);
    chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    e.rdata = 32'h0000_0060; e.err = 1'b0; e.to = 1'b0; e.lat = 3; e.acc = 1; e.acc_cyc = cyc;
    e.paddr = UART_REG_STATUS; e.pwrite = 1'b0; e.pwdata = 32'h0; e.pstrb = 4'h0;
    sbq.push_back(e);
    @(posedge pclk); #1;
    cmd_valid = 1'b0; cmd_addr = '0;
    wait_rsp(g);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
